// File: rtl/seq10010_pkg.sv
// seq10010_pkg: shared encodings and preamble constants for the 10010 serial line (transmitter and detector)
package seq10010_pkg;
  localparam int PAT_W = 5;
  localparam logic [PAT_W-1:0] PATTERN = 5'b10010;
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    PRE  = 3'b001,
    DATA = 3'b010,
    PAR  = 3'b011,
    DONE = 3'b100
  } state_t;
endpackage

// File: rtl/seq10010_tx_piso.sv
// piso_shift: parallel-load, shift-left register exposing its MSB as the serial bit
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);
  logic [DATA_W-1:0] sr;
  // load wins over shift; shifting left presents the next payload bit at the MSB
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (load) sr <= din;
    else if (shift) sr <= sr << 1;
  assign msb = sr[DATA_W-1];
endmodule

// File: rtl/seq10010_tx.sv
// seq10010_tx: 10010-preamble serial frame transmitter; optional even-parity bit under SEQ10010_TX_PARITY_EN
module seq10010_tx #(
  parameter int                 DATA_W  = 8,
  parameter int                 PAT_W   = seq10010_pkg::PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN = seq10010_pkg::PATTERN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              j,
  output logic              busy,
  output logic              done
);
  import seq10010_pkg::*;
  localparam int CW = $clog2(DATA_W > PAT_W ? DATA_W : PAT_W);
  localparam int PW = $clog2(PAT_W);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            load, shift, msb, last, par_bit;
  assign load  = state_q == IDLE && start;
  assign shift = state_q == DATA;
  assign last  = cnt_q == '0;
  piso_shift #(.DATA_W(DATA_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (din),
    .msb   (msb)
  );
`ifdef SEQ10010_TX_PARITY_EN
  logic par_q;
  // parity is taken from the word as accepted, so later din changes cannot affect it
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= 1'b0;
    else if (load) par_q <= ^din;
  assign par_bit = state_q == PAR && par_q;
`else
  assign par_bit = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // bit counter: preamble index in PRE, remaining payload bits in DATA
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= CW'(PAT_W - 1);
    else if (state_q == PRE && last) cnt_q <= CW'(DATA_W - 1);
    else if ((state_q == PRE || state_q == DATA) && !last) cnt_q <= cnt_q - 1'b1;
  // next-state logic; start only matters in IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? PRE : IDLE;
      PRE:     state_d = last ? DATA : PRE;
`ifdef SEQ10010_TX_PARITY_EN
      DATA:    state_d = last ? PAR : DATA;
      PAR:     state_d = DONE;
`else
      DATA:    state_d = last ? DONE : DATA;
`endif
      default: state_d = IDLE;
    endcase
  end
  // Moore outputs decoded purely from registered state, counter and shift register
  always_comb begin
    j    = state_q == PRE ? PATTERN[PW'(cnt_q)] : state_q == DATA ? msb : par_bit;
    busy = state_q != IDLE && state_q != DONE;
    done = state_q == DONE;
  end
endmodule
